// File: rtl/data_mem_hs.sv
// Register-built data memory with valid/ready request channel, byte-lane writes,
// out-of-range error reporting and a combinational debug read port.
module data_mem_hs #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 20,
    parameter int unsigned LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    input  logic [ADDR_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 3;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              complete;
    logic              lat_we;
    logic [NB-1:0]     lat_wstrb;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_in_range;
    logic              dbg_in_range;
    logic              wr_en;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign lat_in_range = {1'b0, lat_addr} < DEPTH_A;
    assign dbg_in_range = {1'b0, dbg_addr} < DEPTH_A;
    assign wr_en        = complete && lat_we && lat_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            lat_we    <= 1'b0;
            lat_wstrb <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            rsp_valid <= complete;
            if (accept) begin
                lat_we    <= req_we;
                lat_wstrb <= req_wstrb;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= CNT_W'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (complete) begin
                if (!lat_in_range) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end else if (lat_we) begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end else begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= mem[lat_addr[IDX_W-1:0]];
                end
            end
        end
    end

    // Each word is its own register so every array element has a single driver.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [DATA_W-1:0] word;

        always_ff @(posedge clk) begin
            if (rst) begin
                word <= '0;
            end else if (wr_en && lat_addr == ADDR_W'(g)) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (lat_wstrb[b]) begin
                        word[8*b +: 8] <= lat_wdata[8*b +: 8];
                    end
                end
            end
        end

        assign mem[g] = word;
    end

    assign dbg_data = (rst || !dbg_in_range) ? '0 : mem[dbg_addr[IDX_W-1:0]];

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs: directed vector table, hand-written
// corner sequences and randomized traffic against an array-based reference.
module tb_data_mem_hs;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DEPTH   = 20;
    localparam int unsigned LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [3:0]        req_wstrb;
    logic [4:0]        req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [4:0]        dbg_addr;
    logic [31:0]       dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc;

    logic [31:0] ref_mem [DEPTH];

    data_mem_hs #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_wstrb(req_wstrb),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_dbg(input logic [4:0] a);
        return (int'(a) < DEPTH) ? ref_mem[a] : 32'h0;
    endfunction

    // Issue one request at a negedge, wait for its response and score it
    // against the reference array; returns at the negedge of the response cycle.
    task automatic do_req(input logic we, input logic [4:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd, input bit noise,
                          output logic [31:0] rd, output logic er);
        bit          got;
        logic [31:0] exp_rd;
        logic        exp_er;
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wd;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        chk("busy_after_accept", {31'b0, req_ready}, 32'd0);
        if (noise) begin
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_addr  = 5'($urandom);
            req_wstrb = 4'($urandom);
            req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                chk("latency", k, LATENCY + 1);
                break;
            end
        end
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 12 cycles");
        end else begin
            rd     = rsp_rdata;
            er     = rsp_err;
            exp_er = !(int'(addr) < DEPTH);
            exp_rd = (!we && !exp_er) ? ref_mem[addr] : 32'h0;
            chk("model_err", {31'b0, er}, {31'b0, exp_er});
            chk("model_rdata", rd, exp_rd);
            if (we && !exp_er) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
                end
            end
            dbg_addr = addr;
            #1;
            chk("dbg_after_access", dbg_data, model_dbg(addr));
        end
    endtask

    task automatic sweep_dbg(input string name);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk(name, dbg_data, model_dbg(5'(a)));
        end
    endtask

    vec_t        vecs [12];
    logic [31:0] rd;
    logic        er;
    int          acc [3];

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wstrb = '0;
        req_addr  = '0;
        req_wdata = '0;
        dbg_addr  = 5'd3;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;

        vecs[0]  = '{1'b1, 5'd5,  4'hF, 32'h0000000D, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 5'd5,  4'h0, 32'h0,        32'h0000000D, 1'b0};
        vecs[2]  = '{1'b1, 5'd7,  4'hF, 32'hFFFFFFE2, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 5'd7,  4'h5, 32'h11223344, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 5'd7,  4'h0, 32'h0,        32'hFF22FF44, 1'b0};
        vecs[5]  = '{1'b1, 5'd20, 4'hF, 32'hDEADBEEF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 5'd31, 4'h0, 32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b1, 5'd5,  4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 5'd5,  4'h0, 32'h0,        32'h0000000D, 1'b0};
        vecs[9]  = '{1'b1, 5'd19, 4'hA, 32'hA1B2C3D4, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 5'd19, 4'h0, 32'h0,        32'hA1000000 | 32'h0000C300, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  4'h0, 32'h0,        32'h0,        1'b0};

        #1;
        chk("dbg_during_reset", dbg_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        sweep_dbg("reset_dbg_zero");
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].strb, vecs[i].wdata, 1'b0, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
        end
        sweep_dbg("oor_no_side_effect");
        @(negedge clk);

        do_req(1'b1, 5'd3, 4'hF, 32'h4, 1'b1, rd, er);
        acc[0] = acc_cyc;
        do_req(1'b0, 5'd3, 4'h0, 32'h0, 1'b1, rd, er);
        acc[1] = acc_cyc;
        chk("b2b_read", rd, 32'h4);
        do_req(1'b1, 5'd3, 4'hF, 32'h0, 1'b0, rd, er);
        acc[2] = acc_cyc;
        chk("b2b_spacing0", acc[1] - acc[0], LATENCY + 1);
        chk("b2b_spacing1", acc[2] - acc[1], LATENCY + 1);
        dbg_addr = 5'd3;
        #1;
        chk("b2b_final_dbg", dbg_data, 32'h0);
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [4:0]  a;
            we = 1'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 5'(20 + $urandom_range(0, 11))
                                             : 5'($urandom_range(0, 19));
            do_req(we, a, 4'($urandom), $urandom, 1'($urandom), rd, er);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("idle_no_rsp", {31'b0, rsp_valid}, 32'd0);
            end
        end
        sweep_dbg("random_final_dbg");
        @(negedge clk);

        do_req(1'b1, 5'd12, 4'hF, 32'h000000AA, 1'b0, rd, er);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'd12;
        req_wstrb = 4'hF;
        req_wdata = 32'h0000000C;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
        #1;
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_no_late_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        dbg_addr = 5'd12;
        #1;
        chk("rst_mid_mem12", dbg_data, 32'h0);
        sweep_dbg("rst_mid_all_zero");
        @(negedge clk);
        do_req(1'b0, 5'd12, 4'h0, 32'h0, 1'b0, rd, er);
        chk("rst_mid_read12", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected end of test");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
Parametrised synchronous data memory for the single-cycle/multi-cycle CPU labs. It generalises the fixed 20-word asynchronous store into a register-built RAM with configurable width, depth and access latency. It has a valid/ready request channel, byte-lane writes, out-of-range error reporting and an asynchronous debug read port for the board display. It sits between the CPU load/store stage and the display/test logic.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 5, word-address width.
DEPTH, 20, number of implemented words; 1 <= DEPTH <= 2**ADDR_W.
LATENCY, 1, wait cycles between acceptance and access; legal range 1..8.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = write, 0 = read.
req_wstrb  in  DATA_W/8  byte-lane write enables; bit i controls bits [8i+7:8i].
req_addr  in  ADDR_W  word address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  one-cycle completion pulse; there is no backpressure.
rsp_rdata  out  DATA_W  read data; valid only while rsp_valid is high.
rsp_err  out  1  address >= DEPTH; valid only while rsp_valid is high.
dbg_addr  in  ADDR_W  debug read address.
dbg_data  out  DATA_W  combinational mem[dbg_addr]; 0 if dbg_addr >= DEPTH.

Behaviour:
- Reset, while rst is high at a clock edge:
  - state <= IDLE; counter <= 0.
  - All DEPTH words <= 0.
  - rsp_valid, rsp_err and rsp_rdata <= 0.
  - Any pending access is discarded and nothing is written.
  - rst has priority over every other event.
- States:
  - IDLE: req_ready = 1. Acceptance happens when req_valid && req_ready at an edge. On acceptance, latch addr, we, wstrb and wdata; counter <= LATENCY-1; go to WAIT.
  - WAIT: req_ready = 0 and request inputs are ignored. If counter != 0, counter decrements. If counter == 0, perform the access at this edge and return to IDLE.
- Access, at the completion edge:
  - If addr >= DEPTH: rsp_err <= 1, rsp_rdata <= 0, no write.
  - Else if we = 1: update only the bytes enabled by wstrb. wstrb = 0 is legal and writes nothing. rsp_rdata <= 0, rsp_err <= 0.
  - Else (read): rsp_rdata <= mem[addr], rsp_err <= 0.
  - rsp_valid <= 1 for exactly one cycle.
- Latency: if a request is accepted in cycle n, rsp_valid is high in cycle n+LATENCY+1.
- Back-to-back: req_ready is 1 again in the same cycle rsp_valid is high, so a new request can be accepted then. Maximum throughput is one request per LATENCY+1 cycles.
- Ordering: only one request is outstanding at a time, so a read always observes every earlier completed write.
- rsp_rdata and rsp_err hold their last values when rsp_valid is low. Consumers must qualify them with rsp_valid.
- Debug port:
  - dbg_data is purely combinational from the memory array and is independent of the handshake.
  - It reflects a write from the cycle after that write's completion edge.
  - During reset it reads 0.
- Address arithmetic: addresses are unsigned with no wrap-around. Addresses DEPTH..2**ADDR_W-1 are out of range.

Test Plan:
- Reset, then sweep dbg_addr over 0..19 -> dbg_data = 0 everywhere; req_ready = 1; rsp_valid = 0.
- LATENCY=2: write addr 5, data 0x0000000D, wstrb 0xF, accepted in cycle 3 -> rsp_valid only in cycle 6, rsp_err = 0, rsp_rdata = 0. Then read addr 5 -> rsp_rdata = 0x0000000D.
- Byte lanes: preload addr 7 with 0xFFFFFFE2, then write 0x11223344 with wstrb 0x5 -> read returns 0xFF22FF44.
- Out of range with DEPTH=20: write addr 20, then read addr 31 -> both have rsp_err = 1 and rsp_rdata = 0. dbg_addr = 20 gives 0, and no in-range word changes.
- Back-to-back: hold req_valid high for three requests (write 3 = 0x4, read 3, write 3 = 0x0) -> acceptances exactly LATENCY+1 cycles apart; the read returns 0x4; the final dbg_data at addr 3 is 0.
- Reset mid-operation: accept a write of 0x0000000C to addr 12, then assert rst during WAIT -> no rsp_valid, mem[12] = 0, and req_ready = 1 in the first cycle after rst deasserts.
